pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage RV64 pipeline. It decides each cycle whether the fetch, decode, execute and memory pipeline registers advance, stall or flush, and it generates the execute-stage operand forwarding selects. It sequences multi-cycle data-memory accesses through a small state machine with a watchdog, and keeps saturating stall and flush performance counters. It sits beside the decode_stage and consumes the control signals decode forwards to execute and later stages.

---
 rtl/pipeline_hazard_ctrl_if.sv | 56 +++++
 rtl/pipeline_hazard_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle shared between the pipeline datapath and
// pipeline_hazard_ctrl.
//
// Decode/execute/memory/writeback fields flow into the controller:
//   Rs1D, Rs2D, UsesRs1D, UsesRs2D, Rs1E, Rs2E, RdE, MemReadEnE,
//   RdM, RdW, RegWriteEnM, RegWriteEnW, PCSF, JALE, MemBusyM
// Pipeline-register controls and status flow back out:
//   StallF/D/E/M, FlushD/E, ForwardAE/BE, MemTimeoutErr,
//   StallCount, FlushCount (CNT_W bits each)
//
// master = pipeline datapath side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic             UsesRs1D;
  logic             UsesRs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic             MemReadEnE;
  logic [4:0]       RdM;
  logic [4:0]       RdW;
  logic             RegWriteEnM;
  logic             RegWriteEnW;
  logic             PCSF;
  logic             JALE;
  logic             MemBusyM;

  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             MemTimeoutErr;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output Rs1D, Rs2D, UsesRs1D, UsesRs2D, Rs1E, Rs2E, RdE, MemReadEnE,
           RdM, RdW, RegWriteEnM, RegWriteEnW, PCSF, JALE, MemBusyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, MemTimeoutErr, StallCount, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, UsesRs1D, UsesRs2D, Rs1E, Rs2E, RdE, MemReadEnE,
           RdM, RdW, RegWriteEnM, RegWriteEnW, PCSF, JALE, MemBusyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, MemTimeoutErr, StallCount, FlushCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage RV64 pipeline.
// Each cycle it decides whether the fetch/decode/execute/memory pipeline
// registers advance, stall or flush, and it produces the execute-stage
// operand forwarding selects. Multi-cycle data-memory accesses are
// sequenced by a RUN / MEM_WAIT / HALT state machine with a watchdog, and
// saturating stall/flush event counters are kept.
//
// Ports:
//   clk  - pipeline clock, rising edge
//   rst  - asynchronous, active-low reset
//   hz   - pipeline_hazard_ctrl_if.slave bundle (hazard inputs, stall/flush/
//          forward controls, MemTimeoutErr, StallCount, FlushCount)
//
// Parameters:
//   TIMEOUT - frozen cycles tolerated before HALT (2..255)
//   CNT_W   - performance counter width (must match the interface CNT_W)
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } stateT;

  // The RUN cycle that first sees MemBusyM is already frozen, so by the time
  // the wait counter holds TIMEOUT-2 the current cycle is frozen cycle number
  // TIMEOUT; HALT is taken on the edge that ends it.
  localparam logic [7:0] LastWait = 8'(TIMEOUT - 2);

  stateT            state;
  stateT            nextState;
  logic [7:0]       waitCnt;
  logic             timeoutErr;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  logic             loadUse;
  logic             freeze;
  logic             evalHazards;
  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             stallM;
  logic             flushD;
  logic             flushE;
  logic [1:0]       fwdA;
  logic [1:0]       fwdB;

  function automatic logic [1:0] forwardSel(input logic [4:0] rs,
                                            input logic [4:0] rdM,
                                            input logic       weM,
                                            input logic [4:0] rdW,
                                            input logic       weW);
    logic [1:0] sel;
    sel = 2'b00;
    if (weM && (rdM != 5'd0) && (rdM == rs))
      sel = 2'b10;
    else if (weW && (rdW != 5'd0) && (rdW == rs))
      sel = 2'b01;
    return sel;
  endfunction

  // State register: the watchdog count only runs while parked in MEM_WAIT and
  // the timeout flag is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      waitCnt    <= 8'd0;
      timeoutErr <= 1'b0;
    end else begin
      state <= nextState;
      if (state != MEM_WAIT)
        waitCnt <= 8'd0;
      else
        waitCnt <= waitCnt + 8'd1;
      if (nextState == HALT)
        timeoutErr <= 1'b1;
    end
  end

  // Next-state and stall/flush decode. A memory freeze outranks a load-use
  // stall, which outranks redirects; a redirect lost to a load-use stall
  // comes back when decode re-presents the instruction.
  always_comb begin
    nextState   = state;
    freeze      = 1'b0;
    evalHazards = 1'b0;
    stallF      = 1'b0;
    stallD      = 1'b0;
    stallE      = 1'b0;
    stallM      = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;

    loadUse = hz.MemReadEnE && (hz.RdE != 5'd0) &&
              ((hz.UsesRs1D && (hz.Rs1D == hz.RdE)) ||
               (hz.UsesRs2D && (hz.Rs2D == hz.RdE)));

    case (state)
      RUN: begin
        if (hz.MemBusyM) begin
          freeze    = 1'b1;
          nextState = MEM_WAIT;
        end else begin
          evalHazards = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.MemBusyM) begin
          freeze = 1'b1;
          if (waitCnt == LastWait)
            nextState = HALT;
        end else begin
          nextState   = RUN;
          evalHazards = 1'b1;
        end
      end
      HALT: begin
        freeze = 1'b1;
      end
      default: begin
        nextState = RUN;
      end
    endcase

    if (freeze) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else if (evalHazards) begin
      if (loadUse) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end else begin
        flushD = hz.PCSF | hz.JALE;
        flushE = hz.JALE;
      end
    end

    fwdA = forwardSel(hz.Rs1E, hz.RdM, hz.RegWriteEnM, hz.RdW, hz.RegWriteEnW);
    fwdB = forwardSel(hz.Rs2E, hz.RdM, hz.RegWriteEnM, hz.RdW, hz.RegWriteEnW);

    // Controls are held quiet for as long as reset is asserted.
    if (!rst) begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      fwdA   = 2'b00;
      fwdB   = 2'b00;
    end
  end

  // Saturating event counters: they stick at all ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallF && (stallCnt != '1))
        stallCnt <= stallCnt + CNT_W'(1);
      if ((flushD || flushE) && (flushCnt != '1))
        flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  assign hz.StallF        = stallF;
  assign hz.StallD        = stallD;
  assign hz.StallE        = stallE;
  assign hz.StallM        = stallM;
  assign hz.FlushD        = flushD;
  assign hz.FlushE        = flushE;
  assign hz.ForwardAE     = fwdA;
  assign hz.ForwardBE     = fwdB;
  assign hz.MemTimeoutErr = timeoutErr;
  assign hz.StallCount    = stallCnt;
  assign hz.FlushCount    = flushCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances share one set
// of inputs: dutA (TIMEOUT=16, CNT_W=32) and dutB (TIMEOUT=4, CNT_W=4, so
// counter saturation and the watchdog are reached quickly). A reference
// model tracks the number of consecutive frozen cycles, a halted flag and
// plain integer counters, and a negedge process compares every output of
// both instances against it. Directed sections pin the model with literal
// expectations; a randomized section follows.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) hzA ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  hzB ();

  pipeline_hazard_ctrl #(.TIMEOUT(16), .CNT_W(32)) dutA (
    .clk (clk),
    .rst (rst),
    .hz  (hzA.slave)
  );

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dutB (
    .clk (clk),
    .rst (rst),
    .hz  (hzB.slave)
  );

  // Both instances see identical pipeline inputs.
  assign hzB.Rs1D        = hzA.Rs1D;
  assign hzB.Rs2D        = hzA.Rs2D;
  assign hzB.UsesRs1D    = hzA.UsesRs1D;
  assign hzB.UsesRs2D    = hzA.UsesRs2D;
  assign hzB.Rs1E        = hzA.Rs1E;
  assign hzB.Rs2E        = hzA.Rs2E;
  assign hzB.RdE         = hzA.RdE;
  assign hzB.MemReadEnE  = hzA.MemReadEnE;
  assign hzB.RdM         = hzA.RdM;
  assign hzB.RdW         = hzA.RdW;
  assign hzB.RegWriteEnM = hzA.RegWriteEnM;
  assign hzB.RegWriteEnW = hzA.RegWriteEnW;
  assign hzB.PCSF        = hzA.PCSF;
  assign hzB.JALE        = hzA.JALE;
  assign hzB.MemBusyM    = hzA.MemBusyM;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end else begin
      nPass++;
    end
  endtask

  // ---------------- reference model ----------------
  int              tmo[2]     = '{16, 4};
  longint unsigned cmax[2]    = '{64'hFFFF_FFFF, 64'hF};
  int              frozenRun[2] = '{0, 0};
  bit              halted[2]  = '{0, 0};
  bit              errM[2]    = '{0, 0};
  longint unsigned scM[2]     = '{0, 0};
  longint unsigned fcM[2]     = '{0, 0};

  function automatic logic modelLoadUse();
    if (!hzA.MemReadEnE || hzA.RdE == 5'd0) return 1'b0;
    return (hzA.UsesRs1D && hzA.Rs1D == hzA.RdE) ||
           (hzA.UsesRs2D && hzA.Rs2D == hzA.RdE);
  endfunction

  function automatic logic [1:0] modelFwd(input logic [4:0] rs);
    if (hzA.RegWriteEnM && hzA.RdM != 5'd0 && hzA.RdM == rs) return 2'b10;
    if (hzA.RegWriteEnW && hzA.RdW != 5'd0 && hzA.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Compare every output of both instances against the model on each cycle,
  // then advance the model to what the coming rising edge will produce.
  always @(negedge clk) begin
    logic       lu;
    logic [1:0] fa;
    logic [1:0] fb;
    lu = modelLoadUse();
    fa = modelFwd(hzA.Rs1E);
    fb = modelFwd(hzA.Rs2E);
    for (int i = 0; i < 2; i++) begin
      logic [3:0]  eStall;
      logic        eFD;
      logic        eFE;
      logic [1:0]  eFA;
      logic [1:0]  eFB;
      logic [3:0]  aStall;
      logic [1:0]  aFlush;
      logic [3:0]  aFwd;
      logic        aErr;
      logic [63:0] aSc;
      logic [63:0] aFc;
      eStall = 4'b0000;
      eFD    = 1'b0;
      eFE    = 1'b0;
      eFA    = fa;
      eFB    = fb;
      if (!rst) begin
        frozenRun[i] = 0;
        halted[i]    = 1'b0;
        errM[i]      = 1'b0;
        scM[i]       = 0;
        fcM[i]       = 0;
        eFA          = 2'b00;
        eFB          = 2'b00;
      end else if (halted[i] || hzA.MemBusyM) begin
        eStall = 4'b1111;
      end else if (lu) begin
        eStall = 4'b1100;
        eFE    = 1'b1;
      end else begin
        eFD = hzA.PCSF | hzA.JALE;
        eFE = hzA.JALE;
      end

      if (i == 0) begin
        aStall = {hzA.StallF, hzA.StallD, hzA.StallE, hzA.StallM};
        aFlush = {hzA.FlushD, hzA.FlushE};
        aFwd   = {hzA.ForwardAE, hzA.ForwardBE};
        aErr   = hzA.MemTimeoutErr;
        aSc    = 64'(hzA.StallCount);
        aFc    = 64'(hzA.FlushCount);
      end else begin
        aStall = {hzB.StallF, hzB.StallD, hzB.StallE, hzB.StallM};
        aFlush = {hzB.FlushD, hzB.FlushE};
        aFwd   = {hzB.ForwardAE, hzB.ForwardBE};
        aErr   = hzB.MemTimeoutErr;
        aSc    = 64'(hzB.StallCount);
        aFc    = 64'(hzB.FlushCount);
      end

      checkOutput($sformatf("dut%0d stalls FDEM", i), 64'(aStall), 64'(eStall));
      checkOutput($sformatf("dut%0d flushes DE", i), 64'(aFlush), 64'({eFD, eFE}));
      checkOutput($sformatf("dut%0d forward AB", i), 64'(aFwd), 64'({eFA, eFB}));
      checkOutput($sformatf("dut%0d timeout err", i), 64'(aErr), 64'(errM[i]));
      checkOutput($sformatf("dut%0d stall count", i), aSc, scM[i]);
      checkOutput($sformatf("dut%0d flush count", i), aFc, fcM[i]);

      if (rst) begin
        if (eStall[3] && scM[i] != cmax[i]) scM[i]++;
        if ((eFD || eFE) && fcM[i] != cmax[i]) fcM[i]++;
        if (!halted[i]) begin
          if (hzA.MemBusyM) begin
            frozenRun[i]++;
            if (frozenRun[i] == tmo[i]) begin
              halted[i] = 1'b1;
              errM[i]   = 1'b1;
            end
          end else begin
            frozenRun[i] = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic stepTo();
    @(posedge clk);
    #1;
  endtask

  task automatic atCheck();
    @(negedge clk);
    #1;
  endtask

  task automatic clearInputs();
    hzA.Rs1D        = 5'd0;
    hzA.Rs2D        = 5'd0;
    hzA.UsesRs1D    = 1'b0;
    hzA.UsesRs2D    = 1'b0;
    hzA.Rs1E        = 5'd0;
    hzA.Rs2E        = 5'd0;
    hzA.RdE         = 5'd0;
    hzA.MemReadEnE  = 1'b0;
    hzA.RdM         = 5'd0;
    hzA.RdW         = 5'd0;
    hzA.RegWriteEnM = 1'b0;
    hzA.RegWriteEnW = 1'b0;
    hzA.PCSF        = 1'b0;
    hzA.JALE        = 1'b0;
    hzA.MemBusyM    = 1'b0;
  endtask

  // Assert reset between edges, check it acted without a clock edge, hold it
  // across a falling edge and release it just after a rising edge.
  task automatic asyncReset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async rst StallF A", 64'(hzA.StallF), 64'd0);
    checkOutput("async rst err A", 64'(hzA.MemTimeoutErr), 64'd0);
    checkOutput("async rst stall count A", 64'(hzA.StallCount), 64'd0);
    checkOutput("async rst stall count B", 64'(hzB.StallCount), 64'd0);
    checkOutput("async rst flush count B", 64'(hzB.FlushCount), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clearInputs();
  endtask

  int burstLeft = 0;

  task automatic applyStimulus(input int cyc);
    stepTo();
    rst             = (cyc % 300 == 299) ? 1'b0 : 1'b1;
    hzA.Rs1D        = 5'($urandom_range(0, 3));
    hzA.Rs2D        = 5'($urandom_range(0, 3));
    hzA.UsesRs1D    = 1'($urandom_range(0, 1));
    hzA.UsesRs2D    = 1'($urandom_range(0, 1));
    hzA.Rs1E        = 5'($urandom_range(0, 3));
    hzA.Rs2E        = 5'($urandom_range(0, 3));
    hzA.RdE         = 5'($urandom_range(0, 3));
    hzA.MemReadEnE  = 1'($urandom_range(0, 1));
    hzA.RdM         = 5'($urandom_range(0, 3));
    hzA.RdW         = 5'($urandom_range(0, 3));
    hzA.RegWriteEnM = 1'($urandom_range(0, 1));
    hzA.RegWriteEnW = 1'($urandom_range(0, 1));
    hzA.PCSF        = ($urandom_range(0, 3) == 0);
    hzA.JALE        = ($urandom_range(0, 5) == 0);
    if (burstLeft > 0) begin
      hzA.MemBusyM = 1'b1;
      burstLeft--;
    end else if ($urandom_range(0, 11) == 0) begin
      hzA.MemBusyM = 1'b1;
      burstLeft    = int'($urandom_range(0, 19));
    end else begin
      hzA.MemBusyM = 1'b0;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b0;
    clearInputs();
    hzA.MemBusyM = 1'b1;
    hzA.PCSF     = 1'b1;
    atCheck();
    atCheck();
    checkOutput("reset StallF forced low", 64'(hzA.StallF), 64'd0);
    checkOutput("reset FlushD forced low", 64'(hzA.FlushD), 64'd0);
    checkOutput("reset stall count", 64'(hzA.StallCount), 64'd0);
    checkOutput("reset err", 64'(hzA.MemTimeoutErr), 64'd0);

    stepTo();
    rst = 1'b1;
    clearInputs();

    // Load-use on rs1 with RdE=5.
    stepTo();
    hzA.MemReadEnE = 1'b1;
    hzA.RdE        = 5'd5;
    hzA.Rs1D       = 5'd5;
    hzA.UsesRs1D   = 1'b1;
    atCheck();
    checkOutput("load-use stalls", 64'({hzA.StallF, hzA.StallD, hzA.StallE, hzA.StallM}), 64'b1100);
    checkOutput("load-use flushes", 64'({hzA.FlushD, hzA.FlushE}), 64'b01);
    checkOutput("load-use count before", 64'(hzA.StallCount), 64'd0);
    stepTo();
    hzA.MemReadEnE = 1'b0;
    atCheck();
    checkOutput("after bubble StallF", 64'(hzA.StallF), 64'd0);
    checkOutput("load-use count after", 64'(hzA.StallCount), 64'd1);
    stepTo();
    hzA.MemReadEnE = 1'b1;
    hzA.RdE        = 5'd0;
    hzA.Rs1D       = 5'd0;
    atCheck();
    checkOutput("RdE=0 no stall", 64'(hzA.StallF), 64'd0);
    stepTo();
    clearInputs();

    // Forwarding.
    hzA.RdM         = 5'd3;
    hzA.RdW         = 5'd3;
    hzA.RegWriteEnM = 1'b1;
    hzA.RegWriteEnW = 1'b1;
    hzA.Rs1E        = 5'd3;
    atCheck();
    checkOutput("fwd A from mem", 64'(hzA.ForwardAE), 64'b10);
    stepTo();
    hzA.RegWriteEnM = 1'b0;
    atCheck();
    checkOutput("fwd A from wb", 64'(hzA.ForwardAE), 64'b01);
    stepTo();
    hzA.RegWriteEnM = 1'b1;
    hzA.Rs2E        = 5'd3;
    hzA.RdM         = 5'd0;
    hzA.RdW         = 5'd0;
    atCheck();
    checkOutput("fwd B x0 none", 64'(hzA.ForwardBE), 64'b00);
    stepTo();
    clearInputs();

    // Redirects.
    hzA.PCSF = 1'b1;
    atCheck();
    checkOutput("PCSF flushes", 64'({hzA.FlushD, hzA.FlushE}), 64'b10);
    checkOutput("flush count pre PCSF", 64'(hzA.FlushCount), 64'd1);
    stepTo();
    hzA.PCSF = 1'b0;
    hzA.JALE = 1'b1;
    atCheck();
    checkOutput("JALE flushes", 64'({hzA.FlushD, hzA.FlushE}), 64'b11);
    checkOutput("flush count pre JALE", 64'(hzA.FlushCount), 64'd2);
    stepTo();
    hzA.JALE       = 1'b0;
    hzA.PCSF       = 1'b1;
    hzA.MemReadEnE = 1'b1;
    hzA.RdE        = 5'd7;
    hzA.Rs2D       = 5'd7;
    hzA.UsesRs2D   = 1'b1;
    atCheck();
    checkOutput("PCSF under load-use FlushD", 64'(hzA.FlushD), 64'd0);
    checkOutput("PCSF under load-use StallF", 64'(hzA.StallF), 64'd1);
    stepTo();
    clearInputs();
    atCheck();
    checkOutput("flush count after redirects", 64'(hzA.FlushCount), 64'd4);
    checkOutput("stall count after redirects", 64'(hzA.StallCount), 64'd2);

    // Single-cycle busy pulse, then a 3-cycle wait.
    stepTo();
    hzA.MemBusyM = 1'b1;
    atCheck();
    checkOutput("pulse freeze", 64'({hzA.StallF, hzA.StallD, hzA.StallE, hzA.StallM}), 64'b1111);
    stepTo();
    hzA.MemBusyM = 1'b0;
    atCheck();
    checkOutput("after pulse not frozen", 64'(hzA.StallF), 64'd0);
    stepTo();
    hzA.MemBusyM = 1'b1;
    for (int k = 0; k < 3; k++) begin
      atCheck();
      checkOutput("mem wait freeze", 64'({hzA.StallF, hzA.StallD, hzA.StallE, hzA.StallM}), 64'b1111);
    end
    stepTo();
    hzA.MemBusyM = 1'b0;
    atCheck();
    checkOutput("mem wait released", 64'(hzA.StallF), 64'd0);
    checkOutput("mem wait no err", 64'(hzA.MemTimeoutErr), 64'd0);
    checkOutput("stall count after waits", 64'(hzA.StallCount), 64'd6);

    // Watchdog on dutA (TIMEOUT=16).
    stepTo();
    hzA.MemBusyM = 1'b1;
    for (int k = 0; k < 16; k++) begin
      atCheck();
      checkOutput("timeout freeze", 64'(hzA.StallF), 64'd1);
      checkOutput("timeout err not yet", 64'(hzA.MemTimeoutErr), 64'd0);
    end
    atCheck();
    checkOutput("timeout err set", 64'(hzA.MemTimeoutErr), 64'd1);
    stepTo();
    hzA.MemBusyM = 1'b0;
    atCheck();
    checkOutput("halt keeps stalls", 64'({hzA.StallF, hzA.StallD, hzA.StallE, hzA.StallM}), 64'b1111);
    checkOutput("halt no flush", 64'({hzA.FlushD, hzA.FlushE}), 64'b00);
    checkOutput("halt err B", 64'(hzB.MemTimeoutErr), 64'd1);
    asyncReset();
    atCheck();
    checkOutput("post halt StallF", 64'(hzA.StallF), 64'd0);

    // Saturation on dutB (CNT_W=4): 20 continuous load-use cycles.
    stepTo();
    hzA.MemReadEnE = 1'b1;
    hzA.RdE        = 5'd9;
    hzA.Rs1D       = 5'd9;
    hzA.UsesRs1D   = 1'b1;
    repeat (20) @(negedge clk);
    atCheck();
    checkOutput("saturated stall count B", 64'(hzB.StallCount), 64'd15);
    checkOutput("unsaturated stall count A", 64'(hzA.StallCount), 64'd20);
    asyncReset();

    for (int cyc = 0; cyc < 3000; cyc++)
      applyStimulus(cyc);
    stepTo();
    rst = 1'b1;
    clearInputs();
    atCheck();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
